// File: rtl/ep_credit_bridge_pkg.sv
// Shared NoC definitions for the endpoint credit bridge: error flag layout and
// sizing helpers for credit counters and index registers.
package ep_credit_bridge_pkg;

  localparam int ERR_CREDIT_OVF = 0;
  localparam int ERR_RX_OVF     = 1;
  localparam int ERR_W          = 2;

  // Counter must represent the full range 0..depth inclusive.
  function automatic int credit_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ep_vc_fifo.sv
// Per-VC first-word-fall-through ejection FIFO; depth B need not be a power of two.
module ep_vc_fifo
  import ep_credit_bridge_pkg::*;
#(
  parameter int Fw = 32,
  parameter int B  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [Fw-1:0] wr_data,
  input  logic          rd_en,
  output logic [Fw-1:0] rd_data,
  output logic          valid,
  output logic          pop,
  output logic          drop
);

  localparam int PW = idx_w(B);
  localparam int CW = credit_cnt_w(B);

  logic [Fw-1:0] mem_q [B];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;
  logic          push;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(B - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == CW'(B));
  assign pop     = valid & rd_en;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push    = wr_en & (~full | pop);
  assign drop    = wr_en & full & ~pop;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ep_credit_bridge.sv
// Endpoint-to-router bridge: credit-gated round-robin injection over V VCs and
// per-VC ejection FIFOs that return credits as flits are consumed.
module ep_credit_bridge
  import ep_credit_bridge_pkg::*;
#(
  parameter int V  = 4,
  parameter int Fw = 32,
  parameter int B  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [V*Fw-1:0]   tx_flit,
  input  logic [V-1:0]      tx_valid,
  output logic [V-1:0]      tx_ready,
  output logic [Fw-1:0]     flit_out,
  output logic              flit_out_wr,
  output logic [V-1:0]      flit_out_vc,
  input  logic [V-1:0]      credit_in,
  input  logic [Fw-1:0]     flit_in,
  input  logic              flit_in_wr,
  input  logic [V-1:0]      flit_in_vc,
  output logic [V-1:0]      credit_out,
  output logic [V*Fw-1:0]   rx_flit,
  output logic [V-1:0]      rx_valid,
  input  logic [V-1:0]      rx_ready,
  output logic [ERR_W-1:0]  err
);

  localparam int CW = credit_cnt_w(B);
  localparam int VW = idx_w(V);

  logic [CW-1:0]    cnt_q [V];
  logic [CW-1:0]    cnt_d [V];
  logic [VW-1:0]    rr_q, rr_d;
  logic [Fw-1:0]    flit_out_q, flit_out_d;
  logic             flit_out_wr_q, flit_out_wr_d;
  logic [V-1:0]     flit_out_vc_q, flit_out_vc_d;
  logic [V-1:0]     credit_out_q, credit_out_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [V-1:0]     grant;
  logic             any_grant;
  logic [VW-1:0]    grant_idx;
  logic [V-1:0]     pop;
  logic [V-1:0]     drop;
  logic             vc_onehot;

  // rr_q holds the first VC to consider, i.e. the one after the last grant.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < V; i++) begin
      idx = (int'(rr_q) + i) % V;
      if (!any_grant && tx_valid[idx] && (cnt_q[idx] != '0)) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = VW'(idx);
      end
    end
    rr_d = rr_q;
    if (any_grant) rr_d = (grant_idx == VW'(V - 1)) ? '0 : grant_idx + VW'(1);
  end

  assign tx_ready = grant;

  always_comb begin
    flit_out_d    = flit_out_q;
    flit_out_vc_d = flit_out_vc_q;
    flit_out_wr_d = any_grant;
    if (any_grant) begin
      flit_out_d    = tx_flit[int'(grant_idx)*Fw +: Fw];
      flit_out_vc_d = grant;
    end
  end

  assign vc_onehot = (flit_in_vc != '0) && ((flit_in_vc & (flit_in_vc - V'(1))) == '0);

  always_comb begin
    err_d        = err_q;
    credit_out_d = pop;
    for (int v = 0; v < V; v++) begin
      cnt_d[v] = cnt_q[v];
      case ({grant[v], credit_in[v]})
        2'b10: cnt_d[v] = cnt_q[v] - CW'(1);
        2'b01: begin
          if (cnt_q[v] == CW'(B)) err_d[ERR_CREDIT_OVF] = 1'b1;
          else                    cnt_d[v] = cnt_q[v] + CW'(1);
        end
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
    if ((|drop) || (flit_in_wr && !vc_onehot)) err_d[ERR_RX_OVF] = 1'b1;
  end

  for (genvar g = 0; g < V; g++) begin : g_vc
    ep_vc_fifo #(
      .Fw (Fw),
      .B  (B)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (flit_in_wr & vc_onehot & flit_in_vc[g]),
      .wr_data (flit_in),
      .rd_en   (rx_ready[g]),
      .rd_data (rx_flit[g*Fw +: Fw]),
      .valid   (rx_valid[g]),
      .pop     (pop[g]),
      .drop    (drop[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) cnt_q[v] <= CW'(B);
      rr_q          <= '0;
      flit_out_q    <= '0;
      flit_out_wr_q <= 1'b0;
      flit_out_vc_q <= '0;
      credit_out_q  <= '0;
      err_q         <= '0;
    end else begin
      for (int v = 0; v < V; v++) cnt_q[v] <= cnt_d[v];
      rr_q          <= rr_d;
      flit_out_q    <= flit_out_d;
      flit_out_wr_q <= flit_out_wr_d;
      flit_out_vc_q <= flit_out_vc_d;
      credit_out_q  <= credit_out_d;
      err_q         <= err_d;
    end
  end

  assign flit_out    = flit_out_q;
  assign flit_out_wr = flit_out_wr_q;
  assign flit_out_vc = flit_out_vc_q;
  assign credit_out  = credit_out_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ep_credit_bridge.sv
// Bench for ep_credit_bridge (V=2, B=4, Fw=32): directed scenarios plus random
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_ep_credit_bridge;

  localparam int V  = 2;
  localparam int FW = 32;
  localparam int B  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [V*FW-1:0] tx_flit = '0;
  logic [V-1:0]    tx_valid = '0;
  logic [V-1:0]    tx_ready;
  logic [FW-1:0]   flit_out;
  logic            flit_out_wr;
  logic [V-1:0]    flit_out_vc;
  logic [V-1:0]    credit_in = '0;
  logic [FW-1:0]   flit_in = '0;
  logic            flit_in_wr = 1'b0;
  logic [V-1:0]    flit_in_vc = '0;
  logic [V-1:0]    credit_out;
  logic [V*FW-1:0] rx_flit;
  logic [V-1:0]    rx_valid;
  logic [V-1:0]    rx_ready = '0;
  logic [1:0]      err;

  always #5 clk = ~clk;

  ep_credit_bridge #(.V(V), .Fw(FW), .B(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_flit     (tx_flit),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .flit_out    (flit_out),
    .flit_out_wr (flit_out_wr),
    .flit_out_vc (flit_out_vc),
    .credit_in   (credit_in),
    .flit_in     (flit_in),
    .flit_in_wr  (flit_in_wr),
    .flit_in_vc  (flit_in_vc),
    .credit_out  (credit_out),
    .rx_flit     (rx_flit),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .err         (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: credits as integers, FIFOs as queues, next-VC pointer.
  int          m_cred [2];
  int          m_start;
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];
  logic [1:0]  m_err;
  logic        exp_wr;
  logic [31:0] exp_fo;
  logic [1:0]  exp_vc;
  logic [1:0]  exp_co;
  int          wr_total = 0;
  int          co_total = 0;

  task automatic model_reset();
    m_cred[0] = B;
    m_cred[1] = B;
    m_start   = 0;
    mq0.delete();
    mq1.delete();
    m_err  = 2'b00;
    exp_wr = 1'b0;
    exp_fo = '0;
    exp_vc = 2'b00;
    exp_co = 2'b00;
  endtask

  initial model_reset();

  always @(negedge clk) begin : cmp
    int g;
    int n;
    int v;
    logic p0, p1;
    if (!reset) model_reset();
    g = -1;
    for (int i = 0; i < 2; i++) begin
      v = (m_start + i) % 2;
      if (g < 0 && tx_valid[v] && m_cred[v] > 0) g = v;
    end
    chk("tx_ready", tx_ready, (g < 0) ? 2'b00 : 2'(1 << g));
    chk("flit_out_wr", flit_out_wr, exp_wr);
    chk("flit_out_vc", flit_out_vc, exp_vc);
    chk("flit_out", flit_out, exp_fo);
    chk("credit_out", credit_out, exp_co);
    chk("err", err, m_err);
    chk("rx_valid", rx_valid, {mq1.size() > 0, mq0.size() > 0});
    if (mq0.size() > 0) chk("rx_flit0", rx_flit[31:0], mq0[0]);
    if (mq1.size() > 0) chk("rx_flit1", rx_flit[63:32], mq1[0]);
    if (flit_out_wr) wr_total++;
    if (credit_out != 2'b00) co_total++;
    if (reset) begin
      p0 = (mq0.size() > 0) && rx_ready[0];
      p1 = (mq1.size() > 0) && rx_ready[1];
      exp_co = {p1, p0};
      exp_wr = (g >= 0);
      if (g >= 0) begin
        exp_fo  = tx_flit[g*32 +: 32];
        exp_vc  = 2'(1 << g);
        m_start = (g + 1) % 2;
      end
      for (int k = 0; k < 2; k++) begin
        n = m_cred[k] - ((g == k) ? 1 : 0) + (credit_in[k] ? 1 : 0);
        if (n > B) begin
          n = B;
          m_err[0] = 1'b1;
        end
        m_cred[k] = n;
      end
      if (p0) void'(mq0.pop_front());
      if (p1) void'(mq1.pop_front());
      if (flit_in_wr) begin
        case (flit_in_vc)
          2'b01: if (mq0.size() < B) mq0.push_back(flit_in); else m_err[1] = 1'b1;
          2'b10: if (mq1.size() < B) mq1.push_back(flit_in); else m_err[1] = 1'b1;
          default: m_err[1] = 1'b1;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tx_flit    = '0;
    tx_valid   = '0;
    credit_in  = '0;
    flit_in    = '0;
    flit_in_wr = 1'b0;
    flit_in_vc = '0;
    rx_ready   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  int base;
  int cnt;

  initial begin
    do_reset();
    #1;
    chk("reset_err", err, 2'b00);
    chk("reset_rx_valid", rx_valid, 2'b00);
    chk("reset_wr", flit_out_wr, 1'b0);
    tick();

    // Scenario 1: VC0 streams without credit return
    base = wr_total;
    for (int k = 0; k < 6; k++) begin
      tx_valid = 2'b01;
      tx_flit[31:0] = 32'hA000_0000 + k;
      #1;
      chk(k < 4 ? "s1_ready_granted" : "s1_ready_blocked", tx_ready[0], (k < 4) ? 1'b1 : 1'b0);
      tick();
    end
    credit_in = 2'b01;
    #1;
    chk("s1_ready_credit_cycle", tx_ready[0], 1'b0);
    tick();
    credit_in = 2'b00;
    #1;
    chk("s1_ready_after_credit", tx_ready[0], 1'b1);
    chk("s1_wr_pulses_4", wr_total - base, 4);
    tick();
    tx_valid = 2'b00;
    #1;
    chk("s1_fifth_wr", flit_out_wr, 1'b1);
    chk("s1_fifth_data", flit_out, 32'hA000_0005);
    tick();

    // Scenario 2: alternating grants
    do_reset();
    tx_valid = 2'b11;
    tx_flit  = {32'hB100_0000, 32'hB000_0000};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s2_vc_alternate", flit_out_vc, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    tx_valid = 2'b00;
    tick();

    // Scenario 3: grant+credit same cycle, then overflow
    do_reset();
    tx_valid = 2'b10;
    tick();
    credit_in = 2'b10;
    #1;
    chk("s3_grant_with_credit", tx_ready, 2'b10);
    tick();
    tx_valid  = 2'b00;
    credit_in = 2'b10;
    tick();
    credit_in = 2'b00;
    #1;
    chk("s3_err_none_at_full", err, 2'b00);
    credit_in = 2'b10;
    tick();
    credit_in = 2'b00;
    #1;
    chk("s3_err_credit_ovf", err, 2'b01);
    tick();

    // Scenario 4: receive overflow, then write paired with pop
    do_reset();
    for (int k = 0; k < 5; k++) begin
      flit_in_wr = 1'b1;
      flit_in_vc = 2'b01;
      flit_in    = 32'hD000_0000 + k;
      tick();
    end
    flit_in_wr = 1'b0;
    #1;
    chk("s4_err_rx_ovf", err, 2'b10);
    chk("s4_head", rx_flit[31:0], 32'hD000_0000);
    base = co_total;
    flit_in_wr = 1'b1;
    flit_in    = 32'hD000_0005;
    rx_ready   = 2'b01;
    tick();
    flit_in_wr = 1'b0;
    rx_ready   = 2'b00;
    #1;
    chk("s4_head_after_pop", rx_flit[31:0], 32'hD000_0001);
    repeat (2) tick();
    chk("s4_credit_pulses", co_total - base, 1);
    cnt = 0;
    rx_ready = 2'b01;
    for (int k = 0; k < 6; k++) begin
      if (rx_valid[0]) cnt++;
      tick();
    end
    rx_ready = 2'b00;
    chk("s4_stored", cnt, 4);

    // Scenario 5: non-one-hot VC
    do_reset();
    flit_in_wr = 1'b1;
    flit_in_vc = 2'b11;
    flit_in    = 32'hEEEE_0000;
    tick();
    flit_in_wr = 1'b0;
    #1;
    chk("s5_err", err, 2'b10);
    chk("s5_rx_valid", rx_valid, 2'b00);
    tick();

    // Scenario 6: reset with buffered flits and used credits
    do_reset();
    for (int k = 0; k < 3; k++) begin
      flit_in_wr = 1'b1;
      flit_in_vc = 2'b01;
      flit_in    = 32'hF000_0000 + k;
      tx_valid   = 2'b01;
      tick();
    end
    clear_inputs();
    #1;
    chk("s6_buffered", rx_valid, 2'b01);
    base = co_total;
    reset = 1'b0;
    #1;
    chk("s6_rx_valid_cleared", rx_valid, 2'b00);
    chk("s6_credit_out_quiet", credit_out, 2'b00);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("s6_no_credit_pulse", co_total - base, 0);
    base = wr_total;
    tx_valid = 2'b01;
    repeat (6) tick();
    tx_valid = 2'b00;
    tick();
    chk("s6_credits_restored", wr_total - base, 4);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      tx_valid   = 2'($urandom);
      tx_flit    = {$urandom, $urandom};
      credit_in  = {($urandom % 6) == 0, ($urandom % 6) == 0};
      flit_in_wr = 1'($urandom);
      flit_in_vc = (($urandom % 8) == 0) ? 2'(($urandom % 2) * 3) : 2'(1 << ($urandom % 2));
      flit_in    = $urandom;
      rx_ready   = 2'($urandom);
      if (c == 300) reset = 1'b0;
      if (c == 302) reset = 1'b1;
      tick();
    end
    clear_inputs();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
